// File: rtl/gamepad_events_if.sv
// Bus bundle between the gamepad event block and its controller: snapshot input,
// control pulses and the event FIFO valid/ready read port.
interface gamepad_events_if #(
    parameter int N_BTN      = 64,
    parameter int FIFO_DEPTH = 16
);
    localparam int IW = $clog2(N_BTN);
    localparam int EW = IW + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [N_BTN-1:0] gp_value;
    logic             gp_stb;
    logic             ctrl_en;
    logic             ctrl_clear;
    logic [EW-1:0]    ev_data;
    logic             ev_valid;
    logic             ev_ready;
    logic [CW-1:0]    ev_count;
    logic             overflow;
    logic             busy;

    modport master (
        output gp_value, gp_stb, ctrl_en, ctrl_clear, ev_ready,
        input  ev_data, ev_valid, ev_count, overflow, busy
    );

    modport slave (
        input  gp_value, gp_stb, ctrl_en, ctrl_clear, ev_ready,
        output ev_data, ev_valid, ev_count, overflow, busy
    );
endinterface

// File: rtl/gamepad_events.sv
// Turns gamepad poll snapshots into press/release events: scans one button per cycle
// against the last reported state and queues changes in a first-word-fall-through FIFO.
module gamepad_events #(
    parameter int N_BTN      = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    gamepad_events_if.slave       bus
);
    localparam int IW = $clog2(N_BTN);
    localparam int EW = IW + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t           state_q, state_d;
    logic [N_BTN-1:0] cur_q, cur_d;
    logic [N_BTN-1:0] prev_q, prev_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [EW-1:0]    mem_q [FIFO_DEPTH];
    logic [EW-1:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;

    logic             full;
    logic             pop;
    logic             push_req;
    logic             accept;

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        prev_d     = prev_q;
        idx_d      = idx_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        push_req   = 1'b0;

        full = (count_q == CW'(FIFO_DEPTH));
        pop  = (count_q != '0) && bus.ev_ready;

        unique case (state_q)
            IDLE: begin
                if (bus.gp_stb && bus.ctrl_en) begin
                    cur_d   = bus.gp_value;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                push_req = (cur_q[idx_q] != prev_q[idx_q]);
                if (idx_q == IW'(N_BTN - 1)) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A push swallowed by ctrl_clear still counts as reported, so prev moves on.
        accept = push_req && (bus.ctrl_clear || !full);
        if (accept) begin
            prev_d[idx_q] = cur_q[idx_q];
        end

        if (bus.ctrl_clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_req && full) begin
                overflow_d = 1'b1;
            end
            if (accept) begin
                mem_d[wr_ptr_q] = {cur_q[idx_q], idx_q};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + {{(CW-1){1'b0}}, accept} - {{(CW-1){1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            prev_q     <= '0;
            idx_q      <= '0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            prev_q     <= prev_d;
            idx_q      <= idx_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.ev_valid = (count_q != '0);
    assign bus.ev_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.ev_count = count_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = (state_q == SCAN);

endmodule

// File: tb/tb_gamepad_events.sv
// Randomized and directed bench for gamepad_events, compared every cycle against a
// queue-based model of the reported button state and event FIFO.
module tb_gamepad_events;
    localparam int N_BTN      = 64;
    localparam int FIFO_DEPTH = 16;
    localparam int IW         = 6;
    localparam int EW         = 7;
    localparam int CW         = 5;
    localparam int OW         = 1 + EW + CW + 1 + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    gamepad_events_if #(.N_BTN(N_BTN), .FIFO_DEPTH(FIFO_DEPTH)) bus();

    gamepad_events #(.N_BTN(N_BTN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [OW-1:0] obs;
    assign obs = {bus.ev_valid, bus.ev_data, bus.ev_count, bus.overflow, bus.busy};

    // Reference model: reported state, snapshot, scan position and the event queue.
    logic [EW-1:0]    m_q[$];
    bit   [N_BTN-1:0] m_cur;
    bit   [N_BTN-1:0] m_prev;
    int               m_pos;
    bit               m_scan;
    bit               m_ovf;

    task automatic model_reset();
        m_q.delete();
        m_cur  = '0;
        m_prev = '0;
        m_pos  = 0;
        m_scan = 0;
        m_ovf  = 0;
    endtask

    task automatic model_step();
        bit full   = (m_q.size() == FIFO_DEPTH);
        bit pop    = (m_q.size() > 0) && bus.ev_ready;
        bit change = m_scan && (m_cur[m_pos] != m_prev[m_pos]);
        if (bus.ctrl_clear) begin
            m_q.delete();
            m_ovf = 0;
            if (change) m_prev[m_pos] = m_cur[m_pos];
        end else begin
            if (pop) void'(m_q.pop_front());
            if (change) begin
                if (full) begin
                    m_ovf = 1;
                end else begin
                    m_q.push_back({m_cur[m_pos], IW'(m_pos)});
                    m_prev[m_pos] = m_cur[m_pos];
                end
            end
        end
        if (m_scan) begin
            if (m_pos == N_BTN - 1) m_scan = 0;
            else m_pos++;
        end else if (bus.gp_stb && bus.ctrl_en) begin
            m_cur  = bus.gp_value;
            m_pos  = 0;
            m_scan = 1;
        end
    endtask

    function automatic logic [OW-1:0] exp_vec();
        logic [EW-1:0] d = (m_q.size() > 0) ? m_q[0] : '0;
        return {m_q.size() > 0, d, CW'(m_q.size()), m_ovf, m_scan};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_stb();
        bus.gp_stb = 1'b1;
        tick();
        bus.gp_stb = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #12;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", obs, {OW{1'b0}});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_idle_scan();
        int busy_cycles = 0;
        bus.gp_value = '0;
        pulse_stb();
        for (int c = 0; c < 70; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL idle_scan cycle %0d: got %h expected %h", c, obs, exp_vec());
            end
            if (bus.busy) busy_cycles++;
            tick();
        end
        checks++;
        if (busy_cycles != N_BTN) begin
            errors++;
            $display("[TB] FAIL idle_scan_busy_len: got %0d expected %0d", busy_cycles, N_BTN);
        end
        checks++;
        if (bus.ev_count !== CW'(0)) begin
            errors++;
            $display("[TB] FAIL idle_scan_count: got %0d expected 0", bus.ev_count);
        end
    endtask

    task automatic test_press_order();
        bus.ev_ready = 1'b0;
        bus.gp_value = '0;
        bus.gp_value[5]  = 1'b1;
        bus.gp_value[63] = 1'b1;
        pulse_stb();
        for (int c = 0; c < 70; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL press_scan cycle %0d: got %h expected %h", c, obs, exp_vec());
            end
            tick();
        end
        checks++;
        if (bus.ev_count !== CW'(2) || bus.ev_data !== 7'h45) begin
            errors++;
            $display("[TB] FAIL press_first: got count %0d data %h expected count 2 data 45",
                     bus.ev_count, bus.ev_data);
        end
        bus.ev_ready = 1'b1;
        tick();
        checks++;
        if (bus.ev_valid !== 1'b1 || bus.ev_data !== 7'h7F) begin
            errors++;
            $display("[TB] FAIL press_second: got valid %b data %h expected valid 1 data 7f",
                     bus.ev_valid, bus.ev_data);
        end
        tick();
        bus.ev_ready = 1'b0;
        checks++;
        if (obs !== exp_vec() || bus.ev_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL press_drained: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_release();
        bus.gp_value[5] = 1'b0;
        pulse_stb();
        for (int c = 0; c < 70; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL release_scan cycle %0d: got %h expected %h", c, obs, exp_vec());
            end
            tick();
        end
        checks++;
        if (bus.ev_count !== CW'(1) || bus.ev_data !== 7'h05) begin
            errors++;
            $display("[TB] FAIL release_event: got count %0d data %h expected count 1 data 05",
                     bus.ev_count, bus.ev_data);
        end
        bus.ev_ready = 1'b1;
        tick();
        bus.ev_ready = 1'b0;
    endtask

    task automatic test_overflow_and_clear();
        logic [N_BTN-1:0] v = bus.gp_value;
        while ($countones(v) < 21) v[$urandom_range(0, 62)] = 1'b1;
        bus.gp_value = v;
        pulse_stb();
        for (int c = 0; c < 70; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL overflow_scan cycle %0d: got %h expected %h", c, obs, exp_vec());
            end
            tick();
        end
        checks++;
        if (bus.ev_count !== CW'(16) || bus.overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_full: got count %0d ovf %b expected count 16 ovf 1",
                     bus.ev_count, bus.overflow);
        end
        bus.ev_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL overflow_drain pop %0d: got %h expected %h", c, obs, exp_vec());
            end
            tick();
        end
        bus.ev_ready = 1'b0;
        pulse_stb();
        for (int c = 0; c < 70; c++) tick();
        checks++;
        if (obs !== exp_vec() || bus.ev_count !== CW'(4)) begin
            errors++;
            $display("[TB] FAIL overflow_rereport: got %h expected %h with count 4", obs, exp_vec());
        end
        bus.ev_ready = 1'b1;
        tick();
        bus.ev_ready = 1'b0;
        checks++;
        if (bus.ev_count !== CW'(3) || bus.overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_setup: got count %0d ovf %b expected count 3 ovf 1",
                     bus.ev_count, bus.overflow);
        end
        bus.ctrl_clear = 1'b1;
        tick();
        bus.ctrl_clear = 1'b0;
        checks++;
        if (bus.ev_count !== CW'(0) || bus.ev_valid !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_result: got count %0d valid %b ovf %b expected 0 0 0",
                     bus.ev_count, bus.ev_valid, bus.overflow);
        end
    endtask

    task automatic test_ignored_stb();
        bus.gp_value = {$urandom, $urandom};
        pulse_stb();
        for (int c = 0; c < 10; c++) tick();
        bus.gp_value = ~bus.gp_value;
        pulse_stb();
        for (int c = 0; c < 70; c++) begin
            bus.ev_ready = $urandom_range(0, 1) == 1;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL midscan_stb cycle %0d: got %h expected %h", c, obs, exp_vec());
            end
            tick();
        end
        bus.ctrl_en  = 1'b0;
        bus.gp_value = {$urandom, $urandom};
        pulse_stb();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (obs !== exp_vec() || bus.busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL disabled_stb cycle %0d: got %h expected %h", c, obs, exp_vec());
            end
            tick();
        end
        bus.ctrl_en  = 1'b1;
        bus.ev_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            bus.ev_ready   = $urandom_range(0, 1) == 1;
            bus.ctrl_en    = $urandom_range(0, 9) != 0;
            bus.ctrl_clear = $urandom_range(0, 199) == 0;
            bus.gp_stb     = $urandom_range(0, 39) == 0;
            if (bus.gp_stb) bus.gp_value = {$urandom, $urandom} & {$urandom, $urandom};
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got %h expected %h", c, obs, exp_vec());
            end
        end
        bus.gp_stb     = 1'b0;
        bus.ctrl_clear = 1'b0;
        bus.ctrl_en    = 1'b1;
        bus.ev_ready   = 1'b0;
    endtask

    task automatic test_reset_midscan();
        logic [N_BTN-1:0] v = '0;
        int lowest = N_BTN;
        while ($countones(v) < 8) v[$urandom_range(0, N_BTN - 1)] = 1'b1;
        for (int i = N_BTN - 1; i >= 0; i--) if (v[i]) lowest = i;
        for (int c = 0; c < 100 && m_scan; c++) tick();
        bus.ctrl_clear = 1'b1;
        tick();
        bus.ctrl_clear = 1'b0;
        bus.gp_value = v;
        pulse_stb();
        for (int c = 0; c < 20; c++) tick();
        rst = 1'b1;
        model_reset();
        #2;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_midscan: got %h expected %h", obs, {OW{1'b0}});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        pulse_stb();
        for (int c = 0; c < 70; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL rescan cycle %0d: got %h expected %h", c, obs, exp_vec());
            end
            tick();
        end
        checks++;
        if (bus.ev_count !== CW'(8) || bus.ev_data !== {1'b1, IW'(lowest)}) begin
            errors++;
            $display("[TB] FAIL rescan_presses: got count %0d data %h expected count 8 data %h",
                     bus.ev_count, bus.ev_data, {1'b1, IW'(lowest)});
        end
    endtask

    initial begin
        bus.gp_value   = '0;
        bus.gp_stb     = 1'b0;
        bus.ctrl_en    = 1'b1;
        bus.ctrl_clear = 1'b0;
        bus.ev_ready   = 1'b0;
        test_reset();
        test_idle_scan();
        test_press_order();
        test_release();
        test_overflow_and_clear();
        test_ignored_stb();
        test_random();
        test_reset_midscan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
